word_cfg_loader: RTL and testbench

WORD_CFG_LOADER -- requirements
Module: word_cfg_loader

---
 rtl/word_cfg_loader.sv | 102 ++++++++++
 tb/tb_word_cfg_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/word_cfg_loader.sv
// Sequences a stream of config bytes into per-block x/y/ab/cx field writes
// for a word array, visiting blocks 0..BLOCKS-1 in order.
module word_cfg_loader #(
  parameter int unsigned BLOCKS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic [7:0] cfg_in,
  output logic [2:0] cfg_addr,
  output logic       set_x,
  output logic       set_y,
  output logic       set_ab,
  output logic       set_cx
);

  localparam int unsigned AW = 3;
  localparam int unsigned FW = 2;
  localparam logic [AW-1:0] LAST_BLK = AW'(BLOCKS - 1);
  localparam logic [FW-1:0] FLD_X    = FW'(0);
  localparam logic [FW-1:0] FLD_Y    = FW'(1);
  localparam logic [FW-1:0] FLD_AB   = FW'(2);
  localparam logic [FW-1:0] FLD_CX   = FW'(3);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   blk;
  logic [FW-1:0]   fld;
  logic            accept;
  logic            last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A transfer coinciding with abort is dropped rather than written.
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = 1'b0;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        accept   = in_valid && !abort;
        last     = accept && (fld == FLD_CX) && (blk == LAST_BLK);
        if (abort || last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Indices sit at zero while idle so every new sequence begins at block 0, field x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk <= '0;
      fld <= '0;
    end else if (state == IDLE) begin
      blk <= '0;
      fld <= '0;
    end else if (accept) begin
      fld <= fld + FW'(1);
      if (fld == FLD_CX) blk <= blk + AW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_in   <= '0;
      cfg_addr <= '0;
      set_x    <= 1'b0;
      set_y    <= 1'b0;
      set_ab   <= 1'b0;
      set_cx   <= 1'b0;
      done     <= 1'b0;
    end else begin
      set_x  <= accept && (fld == FLD_X);
      set_y  <= accept && (fld == FLD_Y);
      set_ab <= accept && (fld == FLD_AB);
      set_cx <= accept && (fld == FLD_CX);
      done   <= last;
      if (accept) begin
        cfg_in   <= in_data;
        cfg_addr <= blk;
      end
    end
  end

endmodule

// File: tb/tb_word_cfg_loader.sv
// Scoreboard bench for word_cfg_loader: an 8-block and a 2-block instance,
// with a reference model predicting each field write and done pulse.
module tb_word_cfg_loader;

  typedef struct {
    logic [7:0] data;
    logic [2:0] addr;
    logic [1:0] fld;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic       start, abort, in_valid;
  logic [7:0] in_data;

  logic       rdy8, busy8, done8, sx8, sy8, sab8, scx8;
  logic [7:0] cin8;
  logic [2:0] cad8;
  logic       rdy2, busy2, done2, sx2, sy2, sab2, scx2;
  logic [7:0] cin2;
  logic [2:0] cad2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  exp_t        sb[$];
  logic        m_busy;
  logic [2:0]  m_blk;
  logic [1:0]  m_fld;
  int unsigned m_blocks;
  logic [7:0]  last_data;
  logic [2:0]  last_addr;

  always #5 clk = ~clk;

  word_cfg_loader #(.BLOCKS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start & ~sel), .abort(abort & ~sel),
    .in_valid(in_valid & ~sel), .in_data(in_data),
    .in_ready(rdy8), .busy(busy8), .done(done8), .cfg_in(cin8), .cfg_addr(cad8),
    .set_x(sx8), .set_y(sy8), .set_ab(sab8), .set_cx(scx8)
  );

  word_cfg_loader #(.BLOCKS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start & sel), .abort(abort & sel),
    .in_valid(in_valid & sel), .in_data(in_data),
    .in_ready(rdy2), .busy(busy2), .done(done2), .cfg_in(cin2), .cfg_addr(cad2),
    .set_x(sx2), .set_y(sy2), .set_ab(sab2), .set_cx(scx2)
  );

  logic       rdy, bsy, dn;
  logic [7:0] cin;
  logic [2:0] cad;
  logic [3:0] strb;
  assign rdy  = sel ? rdy2  : rdy8;
  assign bsy  = sel ? busy2 : busy8;
  assign dn   = sel ? done2 : done8;
  assign cin  = sel ? cin2  : cin8;
  assign cad  = sel ? cad2  : cad8;
  assign strb = sel ? {scx2, sab2, sy2, sx2} : {scx8, sab8, sy8, sx8};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, predict its effect, then advance past the edge.
  task automatic step(input logic s, input logic a, input logic v, input logic [7:0] d);
    exp_t e;
    start = s; abort = a; in_valid = v; in_data = d;
    check("in_ready", 32'(rdy), 32'(m_busy));
    check("busy", 32'(bsy), 32'(m_busy));
    if (m_busy) begin
      if (a) m_busy = 1'b0;
      else if (v) begin
        e.data = d; e.addr = m_blk; e.fld = m_fld;
        e.done = (m_fld == 2'd3) && (32'(m_blk) == m_blocks - 1);
        sb.push_back(e);
        if (m_fld == 2'd3) m_blk = m_blk + 3'd1;
        m_fld = m_fld + 2'd1;
        if (e.done) m_busy = 1'b0;
      end
    end else if (s && !a) begin
      m_busy = 1'b1; m_blk = '0; m_fld = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_blk = '0; m_fld = '0;
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"},  32'(rdy),  32'd0);
    check({tag, "_busy"}, 32'(bsy),  32'd0);
    check({tag, "_done"}, 32'(dn),   32'd0);
    check({tag, "_cin"},  32'(cin),  32'd0);
    check({tag, "_cad"},  32'(cad),  32'd0);
    check({tag, "_strb"}, 32'(strb), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1 check_all_zero("rst");
    step(1'b0, 1'b0, 1'b1, 8'h33);
    rst = 1'b0;
  endtask

  // Monitor: each strobe must match the oldest predicted write; otherwise outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      last_data = '0;
      last_addr = '0;
    end
    if (strb != 4'd0) begin
      if (sb.size() == 0) check("unexpected_strobe", 32'(strb), 32'd0);
      else begin
        e = sb.pop_front();
        check("cfg_in", 32'(cin), 32'(e.data));
        check("cfg_addr", 32'(cad), 32'(e.addr));
        check("strobe", 32'(strb), 32'(4'd1 << e.fld));
        check("done", 32'(dn), 32'(e.done));
        last_data = e.data;
        last_addr = e.addr;
      end
    end else begin
      check("done_no_strobe", 32'(dn), 32'd0);
      check("cfg_in_hold", 32'(cin), 32'(last_data));
      check("cfg_addr_hold", 32'(cad), 32'(last_addr));
    end
  end

  initial begin
    rst = 1'b1; sel = 1'b0; start = 0; abort = 0; in_valid = 0; in_data = '0;
    m_blocks = 8;
    model_reset();
    #2 check_all_zero("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back full sequence
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 32; i++) step(0, 0, 1, 8'(i));
    repeat (3) step(0, 0, 0, 8'h00);

    // Valid toggling 1/0
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 1, 8'(i));
      step(0, 0, 0, 8'hEE);
    end
    repeat (2) step(0, 0, 0, 8'h00);

    // Abort with the 6th byte, then idle in_valid is ignored
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 8'(8'h10 + i));
    step(0, 1, 1, 8'hA5);
    repeat (3) step(0, 0, 1, 8'h55);
    check("abort_last_addr", 32'(cad), 32'd1);
    check("abort_last_strb", 32'(strb), 32'd0);

    // start during LOAD is ignored
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h40 + i));
    step(1, 0, 0, 8'h00);
    for (int i = 4; i < 32; i++) step(0, 0, 1, 8'(8'h40 + i));
    repeat (2) step(0, 0, 0, 8'h00);

    // abort and start together in IDLE: stay idle
    step(1, 1, 0, 8'h00);
    repeat (2) step(0, 0, 1, 8'h77);

    // Reset mid-sequence after 10 transfers
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 8'(8'h80 + i));
    do_reset();
    repeat (3) step(0, 0, 1, 8'h99);

    // Two-block instance, then restart
    sel = 1'b1;
    m_blocks = 2;
    do_reset();
    step(1, 0, 0, 8'h00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'hC0 + i));
    repeat (2) step(0, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00);
    step(0, 0, 1, 8'hD0);
    repeat (2) step(0, 0, 0, 8'h00);
    check("b2_restart_addr", 32'(cad), 32'd0);
    check("b2_restart_data", 32'(cin), 32'hD0);

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
